mem_bridge_arb: RTL and testbench

MEM_BRIDGE_ARB -- requirements
Module: mem_bridge_arb

---
 rtl/mem_bridge_pkg.sv | 24 ++
 rtl/mem_bridge_rr.sv | 46 ++++
 rtl/mem_bridge_arb.sv | 148 ++++++++++++++
 tb/tb_mem_bridge_arb.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the instruction/data memory bridge arbiter.
// Holds FSM encodings, channel ids and the legal LATENCY range.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic CH_IB = 1'b0;
    localparam logic CH_DB = 1'b1;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    function automatic int lat_clamp(input int lat);
        if (lat < LAT_MIN) return LAT_MIN;
        if (lat > LAT_MAX) return LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_bridge_rr.sv
// Two-channel grant logic: fixed db priority, or round-robin on ties
// when MEM_BRIDGE_RR_ARB_EN is defined (adds the last-winner register).
module mem_bridge_rr
    import mem_bridge_pkg::*;
(
`ifdef MEM_BRIDGE_RR_ARB_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic ib_req,
    input  logic db_req,
    output logic ib_gnt,
    output logic db_gnt,
    output logic gnt_id
);

    logic pick_db;

`ifdef MEM_BRIDGE_RR_ARB_EN
    logic last_id;

    // Reset to "ib last" so the first tie goes to db.
    always_ff @(posedge clk) begin
        if (rst)
            last_id <= CH_IB;
        else if (ib_gnt || db_gnt)
            last_id <= gnt_id;
    end

    always_comb begin
        pick_db = db_req && (!ib_req || (last_id == CH_IB));
    end
`else
    always_comb begin
        pick_db = db_req;
    end
`endif

    always_comb begin
        db_gnt = arb_en && pick_db;
        ib_gnt = arb_en && ib_req && !pick_db;
        gnt_id = pick_db ? CH_DB : CH_IB;
    end

endmodule

// File: rtl/mem_bridge_arb.sv
// Bridges a fetch port and a load/store port onto one memory port.
// Optional macro MEM_BRIDGE_RR_ARB_EN selects round-robin tie breaking.
module mem_bridge_arb
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ib_req,
    input  logic [ADDR_W-1:0]   ib_addr,
    output logic                ib_gnt,
    output logic                ib_rvalid,
    output logic [DATA_W-1:0]   ib_rdata,
    input  logic                db_req,
    input  logic                db_we,
    input  logic [ADDR_W-1:0]   db_addr,
    input  logic [DATA_W-1:0]   db_wdata,
    input  logic [DATA_W/8-1:0] db_sel,
    output logic                db_gnt,
    output logic                db_rvalid,
    output logic [DATA_W-1:0]   db_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SEL_W = DATA_W / 8;
    localparam logic [3:0] WAIT_INIT = 4'(lat_clamp(LATENCY) - 1);

    state_t state;
    state_t state_nxt;

    logic [3:0]        cnt;
    logic              arb_en;
    logic              any_gnt;
    logic              gnt_id;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [SEL_W-1:0]  lat_sel;
    logic [DATA_W-1:0] rd_val;

    // Grants are only offered from a live IDLE cycle.
    assign arb_en  = (state == ST_IDLE) && !rst;
    assign any_gnt = ib_gnt || db_gnt;

    mem_bridge_rr u_rr (
`ifdef MEM_BRIDGE_RR_ARB_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .arb_en (arb_en),
        .ib_req (ib_req),
        .db_req (db_req),
        .ib_gnt (ib_gnt),
        .db_gnt (db_gnt),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_gnt)
                    state_nxt = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt <= 4'd1)
                    state_nxt = ST_ACCESS;
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state == ST_ACCESS);
        mem_we    = mem_en && lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_wmask = lat_sel;
        ib_rvalid = (state == ST_RESP) && (lat_id == CH_IB);
        db_rvalid = (state == ST_RESP) && (lat_id == CH_DB);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 4'd0;
        else if (any_gnt)
            cnt <= WAIT_INIT;
        else if (state == ST_WAIT)
            cnt <= cnt - 4'd1;
    end

    // Fetches are read-only full-width accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_id    <= CH_IB;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_sel   <= '0;
        end else if (any_gnt) begin
            lat_id <= gnt_id;
            if (gnt_id == CH_DB) begin
                lat_we    <= db_we;
                lat_addr  <= db_addr;
                lat_wdata <= db_wdata;
                lat_sel   <= db_sel;
            end else begin
                lat_we    <= 1'b0;
                lat_addr  <= ib_addr;
                lat_wdata <= '0;
                lat_sel   <= '1;
            end
        end
    end

    assign rd_val = lat_we ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ib_rdata <= '0;
            db_rdata <= '0;
        end else if (state == ST_ACCESS) begin
            if (lat_id == CH_DB)
                db_rdata <= rd_val;
            else
                ib_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_mem_bridge_arb.sv
// Directed bench for mem_bridge_arb: three instances with LATENCY 1, 3, 4.
// Expected arbitration order follows MEM_BRIDGE_RR_ARB_EN.
module tb_mem_bridge_arb;

    logic        clk;
    logic        rst       [3];
    logic        ib_req    [3];
    logic [31:0] ib_addr   [3];
    logic        ib_gnt    [3];
    logic        ib_rvalid [3];
    logic [31:0] ib_rdata  [3];
    logic        db_req    [3];
    logic        db_we     [3];
    logic [31:0] db_addr   [3];
    logic [31:0] db_wdata  [3];
    logic [3:0]  db_sel    [3];
    logic        db_gnt    [3];
    logic        db_rvalid [3];
    logic [31:0] db_rdata  [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_wmask [3];
    logic [31:0] mem_rdata [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_bridge_arb #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .ib_req    (ib_req[g]),
            .ib_addr   (ib_addr[g]),
            .ib_gnt    (ib_gnt[g]),
            .ib_rvalid (ib_rvalid[g]),
            .ib_rdata  (ib_rdata[g]),
            .db_req    (db_req[g]),
            .db_we     (db_we[g]),
            .db_addr   (db_addr[g]),
            .db_wdata  (db_wdata[g]),
            .db_sel    (db_sel[g]),
            .db_gnt    (db_gnt[g]),
            .db_rvalid (db_rvalid[g]),
            .db_rdata  (db_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wmask (mem_wmask[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic exp_db;

        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b1;
            ib_req[i]    = 1'b1;
            ib_addr[i]   = '0;
            db_req[i]    = 1'b1;
            db_we[i]     = 1'b0;
            db_addr[i]   = '0;
            db_wdata[i]  = '0;
            db_sel[i]    = '0;
            mem_rdata[i] = '0;
        end
        repeat (3) cyc();
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ib_gnt", ib_gnt[i], 0);
            check("rst_db_gnt", db_gnt[i], 0);
            check("rst_mem_en", mem_en[i], 0);
            check("rst_mem_we", mem_we[i], 0);
            check("rst_rvalid", {ib_rvalid[i], db_rvalid[i]}, 0);
            check("rst_rdata", {ib_rdata[i], db_rdata[i]}, 0);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            rst[i]    = 1'b0;
            ib_req[i] = 1'b0;
            db_req[i] = 1'b0;
        end

        // LATENCY=1 fetch
        cyc();
        ib_req[0]    = 1'b1;
        ib_addr[0]   = 32'h8000_0000;
        mem_rdata[0] = 32'h0000_0413;
        #1;
        check("A_ib_gnt", ib_gnt[0], 1);
        check("A_db_gnt", db_gnt[0], 0);
        cyc();
        ib_req[0] = 1'b0;
        #1;
        check("A_mem_en", mem_en[0], 1);
        check("A_mem_addr", mem_addr[0], 32'h8000_0000);
        check("A_mem_we", mem_we[0], 0);
        check("A_wmask", mem_wmask[0], 4'hf);
        check("A_gnt_busy", ib_gnt[0], 0);
        cyc();
        #1;
        check("A_ib_rvalid", ib_rvalid[0], 1);
        check("A_ib_rdata", ib_rdata[0], 32'h0000_0413);
        check("A_db_rvalid", db_rvalid[0], 0);
        check("A_mem_en_off", mem_en[0], 0);
        cyc();
        #1;
        check("A_rvalid_off", ib_rvalid[0], 0);
        check("A_rdata_hold", ib_rdata[0], 32'h0000_0413);

        // LATENCY=3 store
        cyc();
        db_req[1]    = 1'b1;
        db_we[1]     = 1'b1;
        db_addr[1]   = 32'h8000_1000;
        db_wdata[1]  = 32'hDEAD_BEEF;
        db_sel[1]    = 4'b0011;
        mem_rdata[1] = 32'h1234_5678;
        #1;
        check("B_db_gnt", db_gnt[1], 1);
        check("B_ib_gnt", ib_gnt[1], 0);
        cyc();
        db_req[1] = 1'b0;
        db_we[1]  = 1'b0;
        #1;
        check("B_mem_en_t1", mem_en[1], 0);
        cyc();
        #1;
        check("B_mem_en_t2", mem_en[1], 0);
        check("B_mem_we_t2", mem_we[1], 0);
        cyc();
        #1;
        check("B_mem_en_t3", mem_en[1], 1);
        check("B_mem_we_t3", mem_we[1], 1);
        check("B_wmask", mem_wmask[1], 4'b0011);
        check("B_wdata", mem_wdata[1], 32'hDEAD_BEEF);
        check("B_addr", mem_addr[1], 32'h8000_1000);
        cyc();
        #1;
        check("B_db_rvalid", db_rvalid[1], 1);
        check("B_db_rdata", db_rdata[1], 0);
        check("B_ib_rvalid", ib_rvalid[1], 0);
        check("B_mem_we_off", mem_we[1], 0);

        // both channels held high on LATENCY=1 instance
        cyc();
        ib_req[0]  = 1'b1;
        db_req[0]  = 1'b1;
        db_we[0]   = 1'b0;
        db_addr[0] = 32'h8000_2000;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_BRIDGE_RR_ARB_EN
            exp_db = (k % 2 == 0);
`else
            exp_db = 1'b1;
`endif
            #1;
            check("C_db_gnt", db_gnt[0], exp_db);
            check("C_ib_gnt", ib_gnt[0], !exp_db);
            cyc();
            #1;
            check("C_no_gnt_access", {ib_gnt[0], db_gnt[0]}, 0);
            cyc();
            #1;
            check("C_db_rvalid", db_rvalid[0], exp_db);
            check("C_ib_rvalid", ib_rvalid[0], !exp_db);
            check("C_no_gnt_resp", {ib_gnt[0], db_gnt[0]}, 0);
            cyc();
        end
        ib_req[0] = 1'b0;
        db_req[0] = 1'b0;

        // LATENCY=4 with reset mid-transaction
        cyc();
        ib_req[2]    = 1'b1;
        ib_addr[2]   = 32'h8000_0040;
        mem_rdata[2] = 32'h55AA_0000;
        #1;
        check("D_ib_gnt", ib_gnt[2], 1);
        cyc();
        ib_req[2] = 1'b0;
        #1;
        check("D_mem_en_t1", mem_en[2], 0);
        cyc();
        rst[2] = 1'b1;
        #1;
        check("D_mem_en_t2", mem_en[2], 0);
        cyc();
        rst[2] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            check("D_abort_mem_en", mem_en[2], 0);
            check("D_abort_rvalid", {ib_rvalid[2], db_rvalid[2]}, 0);
            check("D_abort_gnt", {ib_gnt[2], db_gnt[2]}, 0);
            cyc();
        end
        rst[2]     = 1'b1;
        db_req[2]  = 1'b1;
        db_we[2]   = 1'b0;
        db_addr[2] = 32'h8000_3000;
        #1;
        check("D_gnt_in_rst", db_gnt[2], 0);
        cyc();
        rst[2] = 1'b0;
        #1;
        check("D_gnt_after_rst", db_gnt[2], 1);
        cyc();
        db_req[2] = 1'b0;
        repeat (3) cyc();
        #1;
        check("D_mem_en_access", mem_en[2], 1);
        check("D_mem_addr", mem_addr[2], 32'h8000_3000);
        cyc();
        #1;
        check("D_db_rvalid", db_rvalid[2], 1);
        check("D_db_rdata", db_rdata[2], 32'h55AA_0000);

        // request arriving during RESP on LATENCY=3 instance
        cyc();
        ib_req[1]    = 1'b1;
        ib_addr[1]   = 32'h8000_0100;
        mem_rdata[1] = 32'hCAFE_0001;
        #1;
        check("E_ib_gnt", ib_gnt[1], 1);
        cyc();
        ib_req[1] = 1'b0;
        repeat (2) cyc();
        #1;
        check("E_mem_en", mem_en[1], 1);
        check("E_wmask", mem_wmask[1], 4'hf);
        cyc();
        db_req[1]  = 1'b1;
        db_we[1]   = 1'b0;
        db_addr[1] = 32'h8000_1100;
        #1;
        check("E_ib_rvalid", ib_rvalid[1], 1);
        check("E_ib_rdata", ib_rdata[1], 32'hCAFE_0001);
        check("E_no_gnt_resp", {ib_gnt[1], db_gnt[1]}, 0);
        cyc();
        #1;
        check("E_db_gnt_idle", db_gnt[1], 1);
        mem_rdata[1] = 32'h0BAD_F00D;
        cyc();
        db_req[1] = 1'b0;
        repeat (2) cyc();
        #1;
        check("E_db_mem_en", mem_en[1], 1);
        check("E_db_mem_we", mem_we[1], 0);
        cyc();
        #1;
        check("E_db_rvalid", db_rvalid[1], 1);
        check("E_db_rdata", db_rdata[1], 32'h0BAD_F00D);
        check("E_ib_rdata_hold", ib_rdata[1], 32'hCAFE_0001);
        check("E_ib_rvalid_off", ib_rvalid[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
